video_pattern_gen: RTL and testbench

//  Video timing and test-pattern source: generates 8-bit RGB, hSync, vSync and data-enable
//  for one raster on a single pixel clock. Drives the red/green/blue/hSync/vSync nets that

---
 rtl/video_timing_pkg.sv | 59 +++++
 rtl/video_timing_counter.sv | 69 ++++++
 rtl/video_pattern_gen.sv | 147 ++++++++++++++
 tb/tb_video_pattern_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing defaults, pattern encoding and colour constants for the
// video pattern generator.
package video_timing_pkg;

  // Counter width; also the width of the x/y coordinate outputs.
  localparam int unsigned CNT_W = 12;

  // Default 640x480@60 raster timing.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Coordinate bit that toggles every 64 pixels, giving 64-pixel checker squares.
  localparam int unsigned CHECK_BIT = 6;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_WHITE = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COL_WHITE   = rgb_t'(24'hFFFFFF);
  localparam rgb_t COL_YELLOW  = rgb_t'(24'hFFFF00);
  localparam rgb_t COL_CYAN    = rgb_t'(24'h00FFFF);
  localparam rgb_t COL_GREEN   = rgb_t'(24'h00FF00);
  localparam rgb_t COL_MAGENTA = rgb_t'(24'hFF00FF);
  localparam rgb_t COL_RED     = rgb_t'(24'hFF0000);
  localparam rgb_t COL_BLUE    = rgb_t'(24'h0000FF);
  localparam rgb_t COL_BLACK   = rgb_t'(24'h000000);

  // Colour of bar idx, left to right.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters with region decode.
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   h_cnt, v_cnt    current column / line (registered)
//   h_active_c      h_cnt inside the visible part of the line
//   de_c            h_cnt and v_cnt both inside the visible area
//   sync_h_c        h_cnt inside the horizontal sync region
//   sync_v_c        v_cnt inside the vertical sync region
//   first_c         position (0,0)
//   line_end_c      last column of a line
//   frame_end_c     last column of the last line
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             h_active_c,
  output logic             de_c,
  output logic             sync_h_c,
  output logic             sync_v_c,
  output logic             first_c,
  output logic             line_end_c,
  output logic             frame_end_c
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Region decode from the current counter state.
  always_comb begin
    line_end_c  = (h_cnt == CNT_W'(H_TOTAL - 1));
    frame_end_c = line_end_c && (v_cnt == CNT_W'(V_TOTAL - 1));
    first_c     = (h_cnt == '0) && (v_cnt == '0);
    h_active_c  = (h_cnt < CNT_W'(H_ACTIVE));
    de_c        = h_active_c && (v_cnt < CNT_W'(V_ACTIVE));
    sync_h_c    = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
    // v_cnt only moves on a line wrap, so vertical sync edges land at h_cnt == 0.
    sync_v_c    = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));
  end

  // Horizontal/vertical raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end_c) begin
      h_cnt <= '0;
      v_cnt <= frame_end_c ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source: RGB, syncs and data enable for one
// raster on a single pixel clock, all outputs registered and mutually aligned.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   pattern_sel         0 bars, 1 gradient, 2 checker, 3 white (applied per frame)
//   red, green, blue    8-bit colour components, zero outside active video
//   hSync, vSync        sync outputs, active level set by HS_POL / VS_POL
//   de                  active video
//   x, y                active pixel coordinates, zero while de = 0
//   frame_start         one-cycle pulse with pixel (0,0)
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pattern_sel,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue,
  output logic             hSync,
  output logic             vSync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_active_c;
  logic             de_c;
  logic             sync_h_c;
  logic             sync_v_c;
  logic             first_c;
  logic             line_end_c;
  logic             frame_end_c;

  pattern_e         pat_q;
  pattern_e         pat_c;
  logic [7:0]       frame_cnt;
  logic [CNT_W-1:0] bar_px;
  logic [2:0]       bar_idx;
  rgb_t             pix_c;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .h_active_c  (h_active_c),
    .de_c        (de_c),
    .sync_h_c    (sync_h_c),
    .sync_v_c    (sync_v_c),
    .first_c     (first_c),
    .line_end_c  (line_end_c),
    .frame_end_c (frame_end_c)
  );

  // Pixel (0,0) is rendered in the same cycle pat_q loads, so bypass the register there.
  assign pat_c = first_c ? pattern_e'(pattern_sel) : pat_q;

  // Frame-level state: latched pattern and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= PAT_BARS;
      frame_cnt <= '0;
    end else begin
      if (first_c) begin
        pat_q <= pattern_e'(pattern_sel);
      end
      if (frame_end_c) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Bar index tracks h_cnt in steps of BAR_W pixels; cleared at each line wrap.
  always_ff @(posedge clk) begin
    if (rst || line_end_c) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (h_active_c) begin
      if (bar_px == CNT_W'(BAR_W - 1)) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + CNT_W'(1);
      end
    end
  end

  // Colour for the current counter position.
  always_comb begin
    pix_c = COL_BLACK;
    if (de_c) begin
      case (pat_c)
        PAT_BARS:  pix_c = bar_colour(bar_idx);
        PAT_GRAD:  pix_c = rgb_t'({h_cnt[7:0], v_cnt[7:0], frame_cnt});
        PAT_CHECK: pix_c = (h_cnt[CHECK_BIT] ^ v_cnt[CHECK_BIT]) ? COL_WHITE : COL_BLACK;
        PAT_WHITE: pix_c = COL_WHITE;
        default:   pix_c = COL_BLACK;
      endcase
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hSync       <= ~HS_POL;
      vSync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      red         <= pix_c.r;
      green       <= pix_c.g;
      blue        <= pix_c.b;
      hSync       <= sync_h_c ? HS_POL : ~HS_POL;
      vSync       <= sync_v_c ? VS_POL : ~VS_POL;
      de          <= de_c;
      x           <= de_c ? h_cnt : '0;
      y           <= de_c ? v_cnt : '0;
      frame_start <= first_c;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: a mid-size raster with positive
// hSync and a tiny raster (22x7) driven with the same randomized pattern and
// reset stimulus. A frame-position model predicts every output cycle.
module tb_video_pattern_gen;

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } obs_t;

  // Index 0: mid-size raster, index 1: tiny raster.
  localparam int P_HA  [2] = '{264, 16};
  localparam int P_HF  [2] = '{4, 2};
  localparam int P_HS  [2] = '{8, 2};
  localparam int P_HB  [2] = '{4, 2};
  localparam int P_VA  [2] = '{72, 4};
  localparam int P_VF  [2] = '{2, 1};
  localparam int P_VS  [2] = '{2, 1};
  localparam int P_VB  [2] = '{3, 1};
  localparam bit P_HP  [2] = '{1'b1, 1'b0};
  localparam bit P_VP  [2] = '{1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pattern_sel;
  logic       measure;

  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, de0, fs0, hs1, vs1, de1, fs1;
  logic [11:0] x0, y0, x1, y1;

  int n_tests = 0;
  int n_fail  = 0;

  obs_t q0[$];
  obs_t q1[$];

  int m_pos [2];
  int m_fno [2];
  int m_pat [2];

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE (P_HA[0]), .H_FP (P_HF[0]), .H_SYNC (P_HS[0]), .H_BP (P_HB[0]),
    .V_ACTIVE (P_VA[0]), .V_FP (P_VF[0]), .V_SYNC (P_VS[0]), .V_BP (P_VB[0]),
    .HS_POL (P_HP[0]), .VS_POL (P_VP[0])
  ) u_med (
    .clk (clk), .rst (rst), .pattern_sel (pattern_sel),
    .red (r0), .green (g0), .blue (b0), .hSync (hs0), .vSync (vs0),
    .de (de0), .x (x0), .y (y0), .frame_start (fs0)
  );

  video_pattern_gen #(
    .H_ACTIVE (P_HA[1]), .H_FP (P_HF[1]), .H_SYNC (P_HS[1]), .H_BP (P_HB[1]),
    .V_ACTIVE (P_VA[1]), .V_FP (P_VF[1]), .V_SYNC (P_VS[1]), .V_BP (P_VB[1]),
    .HS_POL (P_HP[1]), .VS_POL (P_VP[1])
  ) u_tiny (
    .clk (clk), .rst (rst), .pattern_sel (pattern_sel),
    .red (r1), .green (g1), .blue (b1), .hSync (hs1), .vSync (vs1),
    .de (de1), .x (x1), .y (y1), .frame_start (fs1)
  );

  function automatic int h_total(input int d);
    return P_HA[d] + P_HF[d] + P_HS[d] + P_HB[d];
  endfunction

  function automatic int frame_len(input int d);
    return h_total(d) * (P_VA[d] + P_VF[d] + P_VS[d] + P_VB[d]);
  endfunction

  function automatic obs_t idle_out(input int d);
    obs_t o;
    o    = '0;
    o.hs = !P_HP[d];
    o.vs = !P_VP[d];
    return o;
  endfunction

  // Expected output for raster position pos of frame fno, using pattern pat.
  function automatic obs_t ref_pixel(input int d, input int pos, input int pat, input int fno);
    obs_t o;
    int h, v, hs0_at, vs0_at;
    logic [23:0] c;
    h      = pos % h_total(d);
    v      = pos / h_total(d);
    hs0_at = P_HA[d] + P_HF[d];
    vs0_at = P_VA[d] + P_VF[d];
    o      = '0;
    o.hs   = (h >= hs0_at && h < hs0_at + P_HS[d]) ? P_HP[d] : !P_HP[d];
    o.vs   = (v >= vs0_at && v < vs0_at + P_VS[d]) ? P_VP[d] : !P_VP[d];
    o.fs   = (pos == 0);
    if (h < P_HA[d] && v < P_VA[d]) begin
      o.de = 1'b1;
      o.x  = 12'(h);
      o.y  = 12'(v);
      case (pat)
        0:       c = bar_tab[h / (P_HA[d] / 8)];
        1:       c = {8'(h % 256), 8'(v % 256), 8'(fno % 256)};
        2:       c = (((h / 64) + (v / 64)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        default: c = 24'hFFFFFF;
      endcase
      {o.r, o.g, o.b} = c;
    end
    return o;
  endfunction

  // Reference model: one expected output per clock edge for each raster.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      obs_t e;
      if (rst) begin
        e        = idle_out(d);
        m_pos[d] = 0;
        m_fno[d] = 0;
      end else begin
        if (m_pos[d] == 0) m_pat[d] = int'(pattern_sel);
        e = ref_pixel(d, m_pos[d], m_pat[d], m_fno[d]);
        m_pos[d] = m_pos[d] + 1;
        if (m_pos[d] == frame_len(d)) begin
          m_pos[d] = 0;
          m_fno[d] = m_fno[d] + 1;
        end
      end
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  end

  // Independent timing measurements on the tiny raster.
  int  per_cnt, de_cnt, h_lo, v_lo, h_per;
  bit  have_fs, have_h;
  logic hs1_prev;

  // Monitor: compares every presented output cycle against the scoreboard.
  always @(negedge clk) begin
    obs_t e, a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {r0, g0, b0, hs0, vs0, de0, x0, y0, fs0};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL med_pixel t=%0t got=%h expected=%h", $time, a, e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {r1, g1, b1, hs1, vs1, de1, x1, y1, fs1};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL tiny_pixel t=%0t got=%h expected=%h", $time, a, e);
      end
    end

    if (!measure) begin
      have_fs = 0; have_h = 0; h_lo = 0; v_lo = 0;
      per_cnt = 0; de_cnt = 0; h_per = 0;
    end else begin
      if (fs1) begin
        if (have_fs) begin
          n_tests++;
          if (per_cnt != 154) begin
            n_fail++;
            $display("FAIL frame_period got=%0d expected=154", per_cnt);
          end
          n_tests++;
          if (de_cnt != 64) begin
            n_fail++;
            $display("FAIL de_per_frame got=%0d expected=64", de_cnt);
          end
        end
        have_fs = 1;
        per_cnt = 1;
        de_cnt  = de1 ? 1 : 0;
      end else begin
        per_cnt++;
        if (de1) de_cnt++;
      end

      if (hs1_prev === 1'b1 && hs1 === 1'b0) begin
        if (have_h) begin
          n_tests++;
          if (h_per != 22) begin
            n_fail++;
            $display("FAIL hsync_period got=%0d expected=22", h_per);
          end
        end
        have_h = 1;
        h_per  = 1;
      end else begin
        h_per++;
      end

      if (hs1 === 1'b0) h_lo++;
      else if (h_lo > 0) begin
        n_tests++;
        if (h_lo != 2) begin
          n_fail++;
          $display("FAIL hsync_width got=%0d expected=2", h_lo);
        end
        h_lo = 0;
      end

      if (vs1 === 1'b0) v_lo++;
      else if (v_lo > 0) begin
        n_tests++;
        if (v_lo != 22) begin
          n_fail++;
          $display("FAIL vsync_width got=%0d expected=22", v_lo);
        end
        v_lo = 0;
      end
    end
    hs1_prev = hs1;
  end

  // Stimulus: random pattern changes, then random mid-frame resets.
  initial begin
    rst         = 1'b1;
    pattern_sel = 2'd0;
    measure     = 1'b0;
    repeat (4) @(negedge clk);
    rst     = 1'b0;
    measure = 1'b1;

    // Long run without reset so the tiny raster's frame counter wraps past 255.
    for (int c = 0; c < 40200; c++) begin
      @(negedge clk);
      if (c > 37500)
        pattern_sel = 2'd1;
      else if ($urandom_range(0, 399) == 0)
        pattern_sel = 2'($urandom_range(0, 3));
    end

    measure = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int gap;
      gap = int'($urandom_range(200, 5000));
      for (int c = 0; c < gap; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 299) == 0) pattern_sel = 2'($urandom_range(0, 3));
      end
      rst = 1'b1;
      pattern_sel = 2'($urandom_range(0, 3));
      repeat (int'($urandom_range(1, 5))) @(negedge clk);
      rst = 1'b0;
    end
    repeat (2000) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
